// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops bytes from the async FIFO read port and packs PACK_N of them into one stream word
//
// Parameters:
//   PACK_N      bytes per output word (2..8)
//   CW          width of m_bcnt, at least clog2(PACK_N+1)
// Ports:
//   rclk        read-domain clock
//   rrst_n      synchronous active-low reset
//   rempty      FIFO empty flag
//   rinc        FIFO pop request (combinational)
//   rdata       FIFO read data, valid the cycle after rinc
//   flush       single-cycle request to emit the partially packed word
//   flush_busy  high while a flush is being processed
//   m_valid     output word valid
//   m_ready     downstream accept
//   m_data      packed word, byte k in lane k
//   m_bcnt      number of valid bytes in m_data
//   m_last      word was produced by a flush
// Build option:
//   FIFO_RD_PACKER_MSB_FIRST_EN  places byte k in lane PACK_N-1-k instead of lane k
module fifo_rd_packer #(
    parameter int PACK_N = 4,
    parameter int CW     = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rempty,
    output logic                rinc,
    input  logic [7:0]          rdata,
    input  logic                flush,
    output logic                flush_busy,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [8*PACK_N-1:0] m_data,
    output logic [CW-1:0]       m_bcnt,
    output logic                m_last
);
    localparam int PW = $clog2(PACK_N + 1);
    localparam logic [PW-1:0] FULL = PW'(PACK_N);
    localparam logic [PW-1:0] TOP  = PW'(PACK_N - 1);

    typedef enum logic [1:0] {PACK, FLUSH_WAIT, FLUSH_EMIT} state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       pcnt, pcnt_eff, pcnt_nx, lane;
    logic                pend;
    logic [8*PACK_N-1:0] pack, pack_nx;
    logic                out_free, emit_due, move;

    assign out_free   = !m_valid || m_ready;
    assign emit_due   = (state == FLUSH_EMIT) && (pcnt != '0);
    assign move       = ((pcnt == FULL) || emit_due) && out_free;
    // A move empties the pack register in the same cycle, so a byte landing now goes to lane 0.
    assign pcnt_eff   = move ? '0 : pcnt;
    assign pcnt_nx    = pcnt_eff + {{(PW-1){1'b0}}, pend};
    // Counting the byte still in flight keeps the pack register from ever overflowing.
    assign rinc       = rrst_n && !rempty && (state == PACK) &&
                        ({1'b0, pcnt_eff} + {{PW{1'b0}}, pend} < {1'b0, FULL});
    assign flush_busy = (state != PACK);

`ifdef FIFO_RD_PACKER_MSB_FIRST_EN
    assign lane = TOP - pcnt_eff;
`else
    assign lane = pcnt_eff;
`endif

    always_comb begin
        pack_nx = move ? '0 : pack;
        if (pend) pack_nx[{lane, 3'b000} +: 8] = rdata;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            PACK:       state_nx = flush ? FLUSH_WAIT : PACK;
            FLUSH_WAIT: state_nx = pend ? FLUSH_WAIT : FLUSH_EMIT;
            FLUSH_EMIT: state_nx = ((pcnt == '0) || out_free) ? PACK : FLUSH_EMIT;
            default:    state_nx = PACK;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state   <= PACK;
            pcnt    <= '0;
            pend    <= 1'b0;
            pack    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_bcnt  <= '0;
            m_last  <= 1'b0;
        end else begin
            state <= state_nx;
            pcnt  <= pcnt_nx;
            pend  <= rinc;
            pack  <= pack_nx;
            if (move) begin
                m_valid <= 1'b1;
                m_data  <= pack;
                m_bcnt  <= CW'(pcnt);
                m_last  <= emit_due;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed and random checks of fifo_rd_packer against a byte-stream model
module tb_fifo_rd_packer;
    localparam int N  = 4;
    localparam int CW = 4;

`ifdef FIFO_RD_PACKER_MSB_FIRST_EN
    localparam logic [8*N-1:0] T1_LAST = 32'h55667788;
    localparam logic [8*N-1:0] T2_WORD = 32'hA1B2C300;
    localparam logic [8*N-1:0] T5_WORD = 32'h01020304;
`else
    localparam logic [8*N-1:0] T1_LAST = 32'h88776655;
    localparam logic [8*N-1:0] T2_WORD = 32'h00C3B2A1;
    localparam logic [8*N-1:0] T5_WORD = 32'h04030201;
`endif

    logic           rclk = 0, rrst_n = 0, rempty = 1, rinc, flush = 0, flush_busy;
    logic           m_valid, m_ready = 0, m_last;
    logic [7:0]     rdata = 0;
    logic [8*N-1:0] m_data;
    logic [CW-1:0]  m_bcnt;

    int checks = 0, errors = 0, pops = 0, pushed = 0;

    logic [7:0]     fifo_q[$];
    logic [7:0]     acc[$];
    logic [8*N-1:0] exp_d[$];
    int             exp_b[$];
    logic           exp_l[$];
    logic [8*N-1:0] last_word = '0;

    logic           hold_v = 0, hl = 0;
    logic [8*N-1:0] hd = '0;
    logic [CW-1:0]  hb = '0;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(.PACK_N(N), .CW(CW)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rinc(rinc), .rdata(rdata),
        .flush(flush), .flush_busy(flush_busy), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_bcnt(m_bcnt), .m_last(m_last)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic emit_acc(input logic last);
        logic [8*N-1:0] w = '0;
        for (int k = 0; k < acc.size(); k++) begin
`ifdef FIFO_RD_PACKER_MSB_FIRST_EN
            w[(N-1-k)*8 +: 8] = acc[k];
`else
            w[k*8 +: 8] = acc[k];
`endif
        end
        exp_d.push_back(w);
        exp_b.push_back(acc.size());
        exp_l.push_back(last);
        acc.delete();
    endtask

    task automatic add_acc(input logic [7:0] b);
        acc.push_back(b);
        if (acc.size() == N) emit_acc(1'b0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        pushed++;
        add_acc(b);
    endtask

    // Reset drops everything packed or pending; bytes still in the FIFO get packed afresh.
    task automatic model_reset();
        acc.delete();
        exp_d.delete();
        exp_b.delete();
        exp_l.delete();
        foreach (fifo_q[i]) add_acc(fifo_q[i]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((fifo_q.size() != 0 || exp_d.size() != 0) && n < 500) begin
            @(negedge rclk);
            #3;
            n++;
        end
        chk("idle_reached", n < 500, 1);
        repeat (4) @(negedge rclk);
    endtask

    task automatic do_flush();
        int n = 0;
        logic had;
        @(negedge rclk);
        flush = 1;
        had = acc.size() > 0;
        if (had) emit_acc(1'b1);
        @(negedge rclk);
        flush = 0;
        #2;
        while (flush_busy === 1'b1 && n < 20) begin
            n++;
            @(negedge rclk);
            #2;
        end
        chk("flush_busy_cycles", n, 2);
        chk("flush_word_valid", m_valid, had);
    endtask

    // FIFO read port: data appears the cycle after a pop, empty flag follows the queue.
    always begin
        @(posedge rclk);
        if (rinc && fifo_q.size() > 0) begin
            rdata <= fifo_q.pop_front();
            pops++;
        end
        @(negedge rclk);
        #1 rempty = (fifo_q.size() == 0);
    end

    always begin
        @(negedge rclk);
        #2;
        if (!rrst_n) hold_v = 0;
        else begin
            if (rinc) chk("rinc_nonempty", rempty, 0);
            if (hold_v) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, hd);
                chk("hold_bcnt", m_bcnt, hb);
                chk("hold_last", m_last, hl);
            end
            if (m_valid && m_ready) begin
                if (exp_d.size() == 0) chk("unexpected_word", m_valid, 0);
                else begin
                    chk("word_data", m_data, exp_d.pop_front());
                    chk("word_bcnt", m_bcnt, exp_b.pop_front());
                    chk("word_last", m_last, exp_l.pop_front());
                end
                last_word = m_data;
                hold_v = 0;
            end else begin
                hold_v = m_valid;
                hd = m_data;
                hb = m_bcnt;
                hl = m_last;
            end
        end
    end

    initial begin
        repeat (3) @(negedge rclk);
        #2;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_bcnt", m_bcnt, 0);
        chk("rst_last", m_last, 0);
        chk("rst_busy", flush_busy, 0);
        chk("rst_rinc", rinc, 0);
        @(negedge rclk);
        rrst_n = 1;
        m_ready = 1;

        for (int i = 1; i <= 8; i++) push_byte(8'(8'h11 * i));
        wait_idle();
        chk("t1_pops", pops, 8);
        chk("t1_last_word", last_word, T1_LAST);

        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        wait_idle();
        do_flush();
        wait_idle();
        chk("t2_flush_word", last_word, T2_WORD);

        do_flush();
        wait_idle();

        @(negedge rclk);
        m_ready = 0;
        for (int i = 0; i < 12; i++) push_byte(8'($urandom));
        repeat (30) @(negedge rclk);
        #2;
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, exp_d[0]);
        chk("bp_rinc", rinc, 0);
        chk("bp_fifo_left", fifo_q.size(), 4);
        @(negedge rclk);
        m_ready = 1;
        wait_idle();
        chk("bp_pops", pops, pushed);

        push_byte(8'h5C);
        push_byte(8'h6D);
        wait_idle();
        @(negedge rclk);
        rrst_n = 0;
        model_reset();
        @(negedge rclk);
        rrst_n = 1;
        #2;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_bcnt", m_bcnt, 0);
        chk("mid_rst_last", m_last, 0);
        chk("mid_rst_busy", flush_busy, 0);
        @(negedge rclk);
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        wait_idle();
        chk("t5_word", last_word, T5_WORD);

        @(negedge rclk);
        push_byte(8'hAA);
        rrst_n = 0;
        model_reset();
        #2;
        chk("rst_hold_rinc", rinc, 0);
        repeat (2) @(negedge rclk);
        chk("rst_fifo_kept", fifo_q.size(), 1);
        rrst_n = 1;
        wait_idle();
        do_flush();
        wait_idle();

        for (int r = 0; r < 10; r++) begin
            int n = $urandom_range(1, 9);
            for (int j = 0; j < n; j++) push_byte(8'($urandom));
            repeat ($urandom_range(5, 25)) begin
                @(negedge rclk);
                m_ready = 1'($urandom);
            end
            @(negedge rclk);
            m_ready = 1;
            wait_idle();
            if ($urandom_range(0, 1) == 1) begin
                do_flush();
                wait_idle();
            end
        end
        chk("total_pops", pops, pushed);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer that sits directly downstream of the async FIFO, in the read clock domain.
- Pops 8-bit bytes via the FIFO's rinc/rempty/rdata interface and packs PACK_N bytes into one word.
- Presents each word on a valid/ready master stream.
- A flush request emits a partial word, tagged with a byte count and a last flag.

Parameters:
- PACK_N, 4: bytes per output word (2..8).
- CW, 4: width of m_bcnt; must be at least clog2(PACK_N+1).

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  reset: synchronous, active-low, sampled on the rclk rising edge.
- rempty  in  1  FIFO empty flag.
- rinc  out  1  FIFO pop request (combinational).
- rdata  in  8  FIFO read data; valid in the cycle after a cycle with rinc=1.
- flush  in  1  single-cycle pulse: emit whatever is packed.
- flush_busy  out  1  high while a flush is in progress.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  8*PACK_N  packed word; byte k lands in lane k (bits 8k+7:8k).
- m_bcnt  out  CW  number of valid bytes in m_data (1..PACK_N).
- m_last  out  1  word produced by a flush.

Behaviour:
- Reset (rrst_n=0 at a rising edge):
  - Clears m_valid, m_data, m_bcnt, m_last, flush_busy, pack register, pcnt and pend. State goes to PACK.
  - A byte in flight at reset is discarded.
  - rinc is 0 while rrst_n=0.
- Internal state:
  - pcnt (0..PACK_N): bytes held in the pack register.
  - pend: 1 when rinc was high last cycle.
- Byte capture: when pend=1, rdata is written to lane pcnt and pcnt increments. Lanes not yet written are held at 0.
- move: pack register copied to the output register and pcnt cleared. Occurs when (pcnt==PACK_N, or a flush emit is due) and the output register is free (m_valid=0 or m_ready=1).
  - On a plain move: m_bcnt=pcnt, m_last=0.
  - A byte captured in the same cycle as a move goes to lane 0 of the emptied pack register.
- pcnt_eff = 0 in a move cycle, else pcnt.
- rinc = rrst_n & !rempty & (state==PACK) & (pcnt_eff + pend < PACK_N).
  - rinc is never asserted while rempty=1.
- Throughput: a continuous non-empty FIFO with m_ready=1 yields one word per PACK_N+1 cycles.
- Output handshake: m_valid, m_data, m_bcnt and m_last hold stable until m_valid & m_ready. m_valid drops after acceptance unless a new move happens in the same cycle.
- FSM states:
  - PACK: normal operation. flush=1 -> FLUSH_WAIT and flush_busy=1.
  - FLUSH_WAIT: rinc=0; wait for pend=0 -> FLUSH_EMIT.
  - FLUSH_EMIT:
    - If pcnt==0: no word is emitted; go to PACK.
    - Else, when the output register is free: move with m_last=1, m_bcnt=pcnt; go to PACK.
    - flush_busy clears on entry to PACK.
  - flush asserted outside PACK is ignored. flush and the last byte arriving together: the byte is packed first, then emitted by the flush.
- Full pack register (pcnt==PACK_N) with the output busy: rinc stays 0 and the FIFO backs up; no byte is lost.
- Reset mid-flush or mid-word: all partial data is dropped; no m_last word is emitted.

Optional Feature:
- Macro: FIFO_RD_PACKER_MSB_FIRST_EN.
- Defined: byte k goes to lane PACK_N-1-k, so the first byte is in the MS lane. Flushed partial words occupy the top lanes; the low lanes are 0.
- Undefined: little-endian lane order as described in Behaviour.

Test Plan:
- Reset, then FIFO preloaded with 8 bytes 0x11..0x88, m_ready=1 -> two words: m_data=0x44332211 then 0x88776655, m_bcnt=4, m_last=0. rinc never high with rempty=1. Exactly 8 pops.
- 3 bytes 0xA1,0xB2,0xC3 then flush pulse -> one word m_data=0x00C3B2A1, m_bcnt=3, m_last=1. flush_busy high from the cycle after flush until the word is loaded.
- Flush with pcnt=0 and pend=0 -> no m_valid pulse; flush_busy high for 2 cycles.
- m_ready=0 with 12 bytes available -> first word held stable, pack register fills to 4, rinc stays 0, FIFO retains 4 bytes. m_ready=1 -> all 3 words delivered in order.
- rrst_n=0 asserted for 1 cycle after 2 bytes packed -> all outputs 0 next cycle. A subsequent 4-byte burst 0x01..0x04 gives 0x04030201.
- With FIFO_RD_PACKER_MSB_FIRST_EN: bytes 0x11..0x44 -> 0x11223344. Flush after 0xAA alone -> 0xAA000000, m_bcnt=1.
